// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit -- fetch program counter with BTB and return-address-stack prediction.
//
// Keeps the current fetch PC and predicts the next one with a direct-mapped
// branch target buffer (2-bit counters for conditional branches) and a
// circular return address stack. Resolved control flow from EX trains the
// BTB; a mispredict redirects fetch and flushes the front of the pipeline.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          synchronous active-high reset
//   i_pc_write       1 = advance PC, 0 = hold (stall)
//   i_ex_update      resolved control-flow instruction in EX
//   i_ex_pc          PC of that instruction
//   i_ex_type        00 branch, 01 jal, 10 call, 11 return
//   i_ex_taken       resolved direction
//   i_ex_target      resolved taken target
//   i_ex_mispredict  redirect required (qualified by i_ex_update)
//   i_ex_redirect_pc correct next PC on mispredict
//   o_address        current fetch PC
//   o_pred_taken     prediction for o_address
//   o_pred_target    predicted next PC
//   o_if_id_flush    flush IF/ID
//   o_id_ex_flush    flush ID/EX
module fetch_pc_unit #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter int              RAS_DEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_pc_write,
    input  logic            i_ex_update,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [1:0]      i_ex_type,
    input  logic            i_ex_taken,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_ex_mispredict,
    input  logic [XLEN-1:0] i_ex_redirect_pc,
    output logic [XLEN-1:0] o_address,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    output logic            o_if_id_flush,
    output logic            o_id_ex_flush
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam int RAS_W = $clog2(RAS_DEPTH);

    localparam logic [1:0]       T_BR   = 2'b00;
    localparam logic [1:0]       T_CALL = 2'b10;
    localparam logic [1:0]       T_RET  = 2'b11;
    localparam logic [XLEN-1:0]  FOUR   = XLEN'(4);
    localparam logic [RAS_W-1:0] RAS_ONE = RAS_W'(1);
    localparam logic [RAS_W:0]   RAS_FULL = (RAS_W+1)'(RAS_DEPTH);

    logic [XLEN-1:0]        r_pc;
    logic [BTB_ENTRIES-1:0] r_btb_vld;
    logic [TAG_W-1:0]       r_btb_tag  [BTB_ENTRIES];
    logic [XLEN-1:0]        r_btb_tgt  [BTB_ENTRIES];
    logic [1:0]             r_btb_type [BTB_ENTRIES];
    logic [1:0]             r_btb_ctr  [BTB_ENTRIES];
    logic [XLEN-1:0]        r_ras      [RAS_DEPTH];
    logic [RAS_W-1:0]       r_ras_ptr;   // next free slot; top is ptr-1
    logic [RAS_W:0]         r_ras_cnt;

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [1:0]       w_type;
    logic [XLEN-1:0]  w_pc4;
    logic             w_ras_empty;
    logic [XLEN-1:0]  w_ras_top;
    logic             w_pred_taken;
    logic [XLEN-1:0]  w_pred_target;

    assign w_idx       = r_pc[IDX_W+1:2];
    assign w_tag       = r_pc[XLEN-1:IDX_W+2];
    assign w_hit       = r_btb_vld[w_idx] && (r_btb_tag[w_idx] == w_tag);
    assign w_type      = r_btb_type[w_idx];
    assign w_pc4       = r_pc + FOUR;
    assign w_ras_empty = (r_ras_cnt == '0);
    assign w_ras_top   = r_ras[r_ras_ptr - RAS_ONE];

    always_comb begin
        w_pred_taken  = 1'b0;
        w_pred_target = w_pc4;
        if (w_hit) begin
            case (w_type)
                T_BR: begin
                    w_pred_taken  = r_btb_ctr[w_idx][1];
                    w_pred_target = r_btb_ctr[w_idx][1] ? r_btb_tgt[w_idx] : w_pc4;
                end
                // A return with nothing on the stack falls through.
                T_RET: begin
                    w_pred_taken  = !w_ras_empty;
                    w_pred_target = w_ras_empty ? w_pc4 : w_ras_top;
                end
                default: begin
                    w_pred_taken  = 1'b1;
                    w_pred_target = r_btb_tgt[w_idx];
                end
            endcase
        end
    end

    // ---------------- control ----------------
    logic w_redirect;
    logic w_adv;
    logic w_push;
    logic w_pop;

    assign w_redirect = i_ex_update & i_ex_mispredict;
    // The RAS only moves when the predicted path is actually followed.
    assign w_adv  = i_pc_write & ~w_redirect;
    assign w_push = w_adv & w_hit & (w_type == T_CALL);
    assign w_pop  = w_adv & w_hit & (w_type == T_RET) & ~w_ras_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset)          r_pc <= RESET_PC;
        else if (w_redirect)  r_pc <= i_ex_redirect_pc;
        else if (i_pc_write)  r_pc <= w_pred_target;
    end

    // ---------------- BTB training ----------------
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic [1:0]       w_u_ctr;

    assign w_u_idx = i_ex_pc[IDX_W+1:2];
    assign w_u_tag = i_ex_pc[XLEN-1:IDX_W+2];
    assign w_u_hit = r_btb_vld[w_u_idx] && (r_btb_tag[w_u_idx] == w_u_tag);
    assign w_u_ctr = r_btb_ctr[w_u_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_btb_vld <= '0;
        end else if (i_ex_update) begin
            if (w_u_hit) begin
                if (i_ex_taken && w_u_ctr != 2'd3)
                    r_btb_ctr[w_u_idx] <= w_u_ctr + 2'd1;
                else if (!i_ex_taken && w_u_ctr != 2'd0)
                    r_btb_ctr[w_u_idx] <= w_u_ctr - 2'd1;
                r_btb_tgt[w_u_idx]  <= i_ex_target;
                r_btb_type[w_u_idx] <= i_ex_type;
            end else if (i_ex_taken) begin
                r_btb_vld[w_u_idx]  <= 1'b1;
                r_btb_tag[w_u_idx]  <= w_u_tag;
                r_btb_tgt[w_u_idx]  <= i_ex_target;
                r_btb_type[w_u_idx] <= i_ex_type;
                r_btb_ctr[w_u_idx]  <= 2'd2;
            end
        end
    end

    // ---------------- RAS ----------------
    // When full, ptr already points at the oldest entry, so a push
    // overwrites it naturally while the count stays saturated.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_push) begin
            r_ras[r_ras_ptr] <= w_pc4;
            r_ras_ptr        <= r_ras_ptr + RAS_ONE;
            if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + 1'b1;
        end else if (w_pop) begin
            r_ras_ptr <= r_ras_ptr - RAS_ONE;
            r_ras_cnt <= r_ras_cnt - 1'b1;
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, i_ex_pc[1:0]};

    assign o_address     = r_pc;
    assign o_pred_taken  = w_pred_taken;
    assign o_pred_target = w_pred_target;
    assign o_if_id_flush = w_redirect;
    assign o_id_ex_flush = w_redirect;
endmodule
